// File: rtl/queuenm_flex.sv
// Circular FIFO with a per-entry modifiable M-section and a write-once N-section, occupancy flags and one-hot head export.
// Optional QUEUENM_FLEX_BYPASS_EN: an empty queue forwards m_din/n_din to dout, and a same-cycle rd lets the entry pass straight through.
module queuenm_flex #(
    parameter int M_WIDTH   = 8,
    parameter int N_WIDTH   = 8,
    parameter int Q_LENGTH  = 16,
    parameter int AF_THRESH = 12,
    localparam int CNT_W    = $clog2(Q_LENGTH + 1)
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [M_WIDTH-1:0]           m_din,
    input  logic [N_WIDTH-1:0]           n_din,
    input  logic                         wr,
    input  logic                         rd,
    input  logic                         flush,
    input  logic [M_WIDTH*Q_LENGTH-1:0]  new_m_vector,
    input  logic [Q_LENGTH-1:0]          modify_vector,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [CNT_W-1:0]             count,
    output logic [Q_LENGTH-1:0]          valid_vector,
    output logic [Q_LENGTH-1:0]          head_onehot,
    output logic [M_WIDTH*Q_LENGTH-1:0]  old_m_vector,
    output logic [M_WIDTH+N_WIDTH-1:0]   dout
);

    localparam logic [Q_LENGTH-1:0] PTR_INIT = Q_LENGTH'(1);

    logic [Q_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [Q_LENGTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [Q_LENGTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [M_WIDTH-1:0]  m_q [Q_LENGTH];
    logic [M_WIDTH-1:0]  m_d [Q_LENGTH];
    logic [N_WIDTH-1:0]  n_q [Q_LENGTH];
    logic [N_WIDTH-1:0]  n_d [Q_LENGTH];

    logic                rd_acc;
    logic                wr_acc;
    logic                bypass_pass;
    logic [M_WIDTH-1:0]  head_m;
    logic [N_WIDTH-1:0]  head_n;

    // Flags depend only on registered count, so no combinational path from wr/rd.
    assign full        = (count_q == CNT_W'(Q_LENGTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_W'(AF_THRESH));
    assign count       = count_q;
    assign valid_vector = valid_q;
    assign head_onehot  = rd_ptr_q;

`ifdef QUEUENM_FLEX_BYPASS_EN
    assign bypass_pass = empty & wr & rd;
`else
    assign bypass_pass = 1'b0;
`endif

    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc) & ~bypass_pass;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        m_d      = m_q;
        n_d      = n_q;
        if (flush) begin
            wr_ptr_d = PTR_INIT;
            rd_ptr_d = PTR_INIT;
            valid_d  = '0;
            count_d  = '0;
        end else begin
            for (int i = 0; i < Q_LENGTH; i++) begin
                if (modify_vector[i] && valid_q[i]) begin
                    m_d[i] = new_m_vector[i*M_WIDTH +: M_WIDTH];
                end
            end
            if (rd_acc) begin
                valid_d  = valid_d & ~rd_ptr_q;
                rd_ptr_d = {rd_ptr_q[Q_LENGTH-2:0], rd_ptr_q[Q_LENGTH-1]};
            end
            // Enqueue is evaluated last so it wins over modify on the same entry.
            if (wr_acc) begin
                for (int i = 0; i < Q_LENGTH; i++) begin
                    if (wr_ptr_q[i]) begin
                        m_d[i] = m_din;
                        n_d[i] = n_din;
                    end
                end
                valid_d  = valid_d | wr_ptr_q;
                wr_ptr_d = {wr_ptr_q[Q_LENGTH-2:0], wr_ptr_q[Q_LENGTH-1]};
            end
            count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // NOTE: entry storage is reset too, so dout and old_m_vector are defined straight out of reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= PTR_INIT;
            rd_ptr_q <= PTR_INIT;
            valid_q  <= '0;
            count_q  <= '0;
            for (int i = 0; i < Q_LENGTH; i++) begin
                m_q[i] <= '0;
                n_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            m_q      <= m_d;
            n_q      <= n_d;
        end
    end

    always_comb begin
        head_m       = '0;
        head_n       = '0;
        old_m_vector = '0;
        for (int i = 0; i < Q_LENGTH; i++) begin
            if (rd_ptr_q[i]) begin
                head_m = head_m | m_q[i];
                head_n = head_n | n_q[i];
            end
            old_m_vector[i*M_WIDTH +: M_WIDTH] = m_q[i];
        end
    end

    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = {head_m, head_n};
`ifdef QUEUENM_FLEX_BYPASS_EN
        end else if (wr) begin
            dout = {m_din, n_din};
`endif
        end
    end

endmodule

// File: tb/tb_queuenm_flex.sv
// Self-checking bench for queuenm_flex: index-based queue model compared every cycle plus directed literal checks.
module tb_queuenm_flex;

    localparam int MW = 8;
    localparam int NW = 8;
    localparam int QL = 16;
    localparam int AF = 12;
    localparam int CW = $clog2(QL + 1);
`ifdef QUEUENM_FLEX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic [MW-1:0]     m_din;
    logic [NW-1:0]     n_din;
    logic              wr, rd, flush;
    logic [MW*QL-1:0]  new_m_vector;
    logic [QL-1:0]     modify_vector;
    logic              full, empty, almost_full;
    logic [CW-1:0]     count;
    logic [QL-1:0]     valid_vector, head_onehot;
    logic [MW*QL-1:0]  old_m_vector;
    logic [MW+NW-1:0]  dout;

    int checks = 0;
    int errors = 0;

    queuenm_flex #(.M_WIDTH(MW), .N_WIDTH(NW), .Q_LENGTH(QL), .AF_THRESH(AF)) dut (
        .clk(clk), .clr(clr), .m_din(m_din), .n_din(n_din), .wr(wr), .rd(rd), .flush(flush),
        .new_m_vector(new_m_vector), .modify_vector(modify_vector), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .valid_vector(valid_vector),
        .head_onehot(head_onehot), .old_m_vector(old_m_vector), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: arrays indexed by integer head/tail plus an occupancy integer.
    logic [MW-1:0] mod_m [QL];
    logic [NW-1:0] mod_n [QL];
    bit            mod_v [QL];
    int            hd, tl, cnt;
    bit            pass, do_rd, do_wr;
    logic [QL-1:0]    e_valid;
    logic [MW*QL-1:0] e_oldm;
    logic [MW+NW-1:0] e_dout;

    always @(negedge clk) begin
        if (!clr) begin
            for (int i = 0; i < QL; i++) begin
                mod_m[i] = '0; mod_n[i] = '0; mod_v[i] = 1'b0;
            end
            hd = 0; tl = 0; cnt = 0;
        end
        for (int i = 0; i < QL; i++) begin
            e_valid[i] = mod_v[i];
            e_oldm[i*MW +: MW] = mod_m[i];
        end
        if (cnt > 0)               e_dout = {mod_m[hd], mod_n[hd]};
        else if (BYP && wr === 1'b1) e_dout = {m_din, n_din};
        else                       e_dout = '0;
        check("m_count", 128'(count), 128'(cnt));
        check("m_full", 128'(full), 128'(cnt == QL));
        check("m_empty", 128'(empty), 128'(cnt == 0));
        check("m_afull", 128'(almost_full), 128'(cnt >= AF));
        check("m_valid", 128'(valid_vector), 128'(e_valid));
        check("m_head", 128'(head_onehot), 128'(QL'(1) << hd));
        check("m_oldm", 128'(old_m_vector), 128'(e_oldm));
        check("m_dout", 128'(dout), 128'(e_dout));
        if (clr) begin
            if (flush) begin
                for (int i = 0; i < QL; i++) mod_v[i] = 1'b0;
                cnt = 0; hd = 0; tl = 0;
            end else begin
                pass  = BYP && cnt == 0 && wr && rd;
                do_rd = rd && cnt > 0;
                do_wr = wr && (cnt < QL || do_rd) && !pass;
                for (int i = 0; i < QL; i++)
                    if (modify_vector[i] && mod_v[i]) mod_m[i] = new_m_vector[i*MW +: MW];
                if (do_rd) begin
                    mod_v[hd] = 1'b0; hd = (hd + 1) % QL; cnt--;
                end
                if (do_wr) begin
                    mod_m[tl] = m_din; mod_n[tl] = n_din; mod_v[tl] = 1'b1;
                    tl = (tl + 1) % QL; cnt++;
                end
            end
        end
    end

    task automatic drive(input bit w, input bit r, input bit f, input logic [MW-1:0] md,
                         input logic [NW-1:0] nd, input logic [QL-1:0] mv, input logic [MW*QL-1:0] nm);
        wr = w; rd = r; flush = f; m_din = md; n_din = nd; modify_vector = mv; new_m_vector = nm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    logic [MW*QL-1:0] all55;
    logic [MW*QL-1:0] allee;

    initial begin
        for (int i = 0; i < QL; i++) begin
            all55[i*MW +: MW] = 8'h55;
            allee[i*MW +: MW] = 8'hEE;
        end
        clr = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        step(); step();
        check("rst_count", 128'(count), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_head", 128'(head_onehot), 128'(16'h0001));
        clr = 1'b1;

        // 1: fill to full, almost_full from the 12th write
        for (int i = 0; i < QL; i++) begin
            drive(1, 0, 0, 8'(i), 8'(8'h10 + i), '0, '0);
            step();
            check("fill_afull", 128'(almost_full), 128'(i >= 11));
        end
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("fill_count", 128'(count), 128'(16));
        check("fill_full", 128'(full), 128'(1));
        check("fill_head", 128'(head_onehot), 128'(16'h0001));
        check("fill_dout", 128'(dout), 128'(16'h0010));

        // 2: wr+rd on full, with a modify on the head/write entry that the enqueue overrides
        drive(1, 1, 0, 8'hAA, 8'h20, 16'h0001, all55);
        peek();
        check("wrrd_pre_dout", 128'(dout), 128'(16'h0010));
        step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("wrrd_dout", 128'(dout), 128'(16'h0111));
        check("wrrd_count", 128'(count), 128'(16));
        check("wrrd_full", 128'(full), 128'(1));
        check("wrrd_m0", 128'(old_m_vector[7:0]), 128'(8'hAA));
        drive(1, 0, 0, 8'hBB, 8'h21, '0, '0);
        step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("drop_count", 128'(count), 128'(16));
        check("drop_m0", 128'(old_m_vector[7:0]), 128'(8'hAA));

        // 3: modify hits valid entry 1, skips invalid entry 4
        drive(0, 0, 1, 8'h00, 8'h00, '0, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'(8'h30 + i), 8'(8'h40 + i), '0, '0);
            step();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 16'h0012, all55);
        step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("mod_m1", 128'(old_m_vector[15:8]), 128'(8'h55));
        check("mod_m4", 128'(old_m_vector[39:32]), 128'(8'h04));
        check("mod_m0", 128'(old_m_vector[7:0]), 128'(8'h30));
        check("mod_dout", 128'(dout), 128'(16'h3040));

        // 4: wrap with alternating wr/rd
        drive(0, 0, 1, 8'h00, 8'h00, '0, '0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 8'(8'h60 + i), 8'(i), '0, '0);
            step();
            drive(0, 1, 0, 8'h00, 8'h00, '0, '0);
            peek();
            check("wrap_dout", 128'(dout), 128'({8'(8'h60 + i), 8'(i)}));
            step();
            if (i == 15) check("wrap_head0", 128'(head_onehot), 128'(16'h0001));
            if (i == 18) check("wrap_head3", 128'(head_onehot), 128'(16'h0008));
        end

        // 5: flush beats wr/rd/modify at count 5
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 8'(8'h70 + i), 8'(8'h80 + i), '0, '0);
            step();
        end
        check("pre_flush_count", 128'(count), 128'(5));
        drive(1, 1, 1, 8'h99, 8'h99, '1, allee);
        step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("flush_count", 128'(count), 128'(0));
        check("flush_empty", 128'(empty), 128'(1));
        check("flush_valid", 128'(valid_vector), 128'(0));
        check("flush_head", 128'(head_onehot), 128'(16'h0001));
        check("flush_keep_m4", 128'(old_m_vector[39:32]), 128'(8'h70));

        // reset mid-operation discards entries immediately
        drive(1, 0, 0, 8'h11, 8'h22, '0, '0);
        step(); step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        #2 clr = 1'b0;
        #1;
        check("arst_count", 128'(count), 128'(0));
        check("arst_dout", 128'(dout), 128'(0));
        check("arst_oldm", 128'(old_m_vector), 128'(0));
        step();
        clr = 1'b1;

        // 6: wr+rd on empty
        drive(1, 1, 0, 8'h3C, 8'h07, '0, '0);
        peek();
        check("empty_wrrd_dout", 128'(dout), BYP ? 128'(16'h3C07) : 128'(0));
        step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("empty_wrrd_count", 128'(count), BYP ? 128'(0) : 128'(1));
        drive(0, 1, 0, 8'h00, 8'h00, '0, '0);
        step(); step();
        drive(0, 0, 0, 8'h00, 8'h00, '0, '0);
        check("rd_empty_count", 128'(count), 128'(0));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
